// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, SRAM
// bus widths and a saturating increment helper for the stall counter.
package mem_arbiter_pkg;

  localparam int RAM_AW = 18;
  localparam int RAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arbState_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one SRAM controller between instruction fetch and
// data ports. Data has fixed priority over fetch; each access holds the SRAM
// bus for WAIT_CYCLES clocks and completes with a one-cycle ack pulse.
// Optional build macro MEM_PERF_CNT_EN adds the perf_stall cycle counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [RAM_AW-1:0] if_addr,
  output logic [RAM_DW-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [RAM_AW-1:0] d_addr,
  input  logic [RAM_DW-1:0] d_wdata,
  output logic [RAM_DW-1:0] d_rdata,
  output logic              d_ack,
  output logic              ram_read,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_wdata,
  input  logic [RAM_DW-1:0] ram_rdata,
`ifdef MEM_PERF_CNT_EN
  output logic              stall,
  output logic [15:0]       perf_stall
`else
  output logic              stall
`endif
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  arbState_t         stateR;
  arbState_t         stateNextS;
  logic [3:0]        cntR;
  logic [RAM_AW-1:0] latchAddrR;
  logic [RAM_DW-1:0] latchWdataR;
  logic              latchWeR;
  logic              latchIsDataR;
  logic              ramReadR;
  logic              startS;
  logic              finishS;

  // Next-state logic plus the start/finish strobes used by the datapath.
  always_comb begin
    stateNextS = stateR;
    startS     = 1'b0;
    finishS    = 1'b0;
    case (stateR)
      IDLE: begin
        if (d_req || if_req) begin
          startS     = 1'b1;
          stateNextS = ACCESS;
        end else begin
          stateNextS = IDLE;
        end
      end
      ACCESS: begin
        if (cntR == 4'd0) begin
          finishS    = 1'b1;
          stateNextS = DONE;
        end else begin
          stateNextS = ACCESS;
        end
      end
      DONE:    stateNextS = IDLE;
      default: stateNextS = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNextS;
    end
  end

  // Wait counter: loaded on grant, counts down through ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntR <= 4'd0;
    end else if (startS) begin
      cntR <= CNT_LOAD;
    end else if (stateR == ACCESS && cntR != 4'd0) begin
      cntR <= cntR - 4'd1;
    end else begin
      cntR <= cntR;
    end
  end

  // Latch the winner's request on grant; data wins over fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latchAddrR   <= {RAM_AW{1'b0}};
      latchWdataR  <= {RAM_DW{1'b0}};
      latchWeR     <= 1'b0;
      latchIsDataR <= 1'b0;
    end else if (startS && d_req) begin
      latchAddrR   <= d_addr;
      latchWdataR  <= d_wdata;
      latchWeR     <= d_we;
      latchIsDataR <= 1'b1;
    end else if (startS) begin
      latchAddrR   <= if_addr;
      latchWdataR  <= {RAM_DW{1'b0}};
      latchWeR     <= 1'b0;
      latchIsDataR <= 1'b0;
    end else begin
      latchAddrR   <= latchAddrR;
      latchWdataR  <= latchWdataR;
      latchWeR     <= latchWeR;
      latchIsDataR <= latchIsDataR;
    end
  end

  // SRAM direction: low only while a write is in ACCESS, reset forces read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramReadR <= 1'b1;
    end else if (startS) begin
      ramReadR <= ~(d_req & d_we);
    end else if (finishS) begin
      ramReadR <= 1'b1;
    end else begin
      ramReadR <= ramReadR;
    end
  end

  // Completion: capture read data on the last ACCESS cycle and raise the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= {RAM_DW{1'b0}};
      d_rdata  <= {RAM_DW{1'b0}};
    end else if (finishS && latchIsDataR) begin
      if_ack   <= 1'b0;
      d_ack    <= 1'b1;
      if_rdata <= if_rdata;
      d_rdata  <= latchWeR ? d_rdata : ram_rdata;
    end else if (finishS) begin
      if_ack   <= 1'b1;
      d_ack    <= 1'b0;
      if_rdata <= ram_rdata;
      d_rdata  <= d_rdata;
    end else begin
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= if_rdata;
      d_rdata  <= d_rdata;
    end
  end

  assign ram_read  = ramReadR;
  assign ram_addr  = latchAddrR;
  assign ram_wdata = latchWdataR;
  assign stall     = (if_req | d_req) & ~(if_ack | d_ack);

`ifdef MEM_PERF_CNT_EN
  logic [15:0] perfStallR;

  // Count stalled cycles, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfStallR <= 16'd0;
    end else if (stall) begin
      perfStallR <= satInc16(perfStallR);
    end else begin
      perfStallR <= perfStallR;
    end
  end

  assign perf_stall = perfStallR;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table vectors, randomized transactions
// against a transaction-level model, and hand sequences for reset-abort,
// WAIT_CYCLES=1 latency and (with MEM_PERF_CNT_EN) stall-counter saturation.
module tb_mem_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // main instance, WAIT_CYCLES = 2
  logic        ifReq = 1'b0, dReq = 1'b0, dWe = 1'b0;
  logic [17:0] ifAddr = 18'd0, dAddr = 18'd0;
  logic [15:0] dWdata = 16'd0, ramRdata = 16'd0;
  logic [15:0] ifRdata, dRdata, ramWdata;
  logic [17:0] ramAddr;
  logic        ifAck, dAck, ramRead, stall;

  // second instance, WAIT_CYCLES = 1
  logic        ifReq1 = 1'b0, dReq1 = 1'b0, dWe1 = 1'b0;
  logic [17:0] ifAddr1 = 18'd0, dAddr1 = 18'd0;
  logic [15:0] dWdata1 = 16'd0, ramRdata1 = 16'd0;
  logic [15:0] ifRdata1, dRdata1, ramWdata1;
  logic [17:0] ramAddr1;
  logic        ifAck1, dAck1, ramRead1, stall1;

`ifdef MEM_PERF_CNT_EN
  logic [15:0] perfStall, perfStall1;
`endif

  mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ack(ifAck),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .d_rdata(dRdata), .d_ack(dAck),
    .ram_read(ramRead), .ram_addr(ramAddr), .ram_wdata(ramWdata),
    .ram_rdata(ramRdata),
`ifdef MEM_PERF_CNT_EN
    .stall(stall), .perf_stall(perfStall)
`else
    .stall(stall)
`endif
  );

  mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(ifReq1), .if_addr(ifAddr1), .if_rdata(ifRdata1), .if_ack(ifAck1),
    .d_req(dReq1), .d_we(dWe1), .d_addr(dAddr1), .d_wdata(dWdata1),
    .d_rdata(dRdata1), .d_ack(dAck1),
    .ram_read(ramRead1), .ram_addr(ramAddr1), .ram_wdata(ramWdata1),
    .ram_rdata(ramRdata1),
`ifdef MEM_PERF_CNT_EN
    .stall(stall1), .perf_stall(perfStall1)
`else
    .stall(stall1)
`endif
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // model of the port read-data registers
  logic [15:0] lastIf = 16'd0;
  logic [15:0] lastD  = 16'd0;

  typedef struct {
    logic        doIf, doD, we;
    logic [17:0] ifA, dA;
    logic [15:0] wd, rdA, rdB;
    int          expIfEdge, expDEdge, expLow;
    logic [15:0] expIfRd, expDRd;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One arbitration round on the main instance. rdA is what the SRAM returns
  // for the first-served access, rdB for the second (after the first ack).
  task automatic runPair(input logic doIf, input logic doD, input logic we,
                         input logic [17:0] ifA, input logic [17:0] dA,
                         input logic [15:0] wd, input logic [15:0] rdA,
                         input logic [15:0] rdB, input int expIfEdge,
                         input int expDEdge, input int expLow,
                         input logic [15:0] expIfRd, input logic [15:0] expDRd,
                         input string tag);
    int ifEdge = 0, dEdge = 0, ifCnt = 0, dCnt = 0, low = 0;
    int stallBad = 0, addrBad = 0;
    @(negedge clk);
    ifReq = doIf; ifAddr = ifA; dReq = doD; dWe = we; dAddr = dA;
    dWdata = wd; ramRdata = rdA;
    for (int n = 1; n <= 2 * (W + 2) + 3; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (!ramRead) begin
        low++;
        if (ramAddr !== dA || ramWdata !== wd) addrBad++;
      end
      if (n == 1) check({tag, " first addr"}, 32'(ramAddr), 32'(doD ? dA : ifA));
      if (doD && doIf && n == W + 3) check({tag, " second addr"}, 32'(ramAddr), 32'(ifA));
      if ((ifReq || dReq) && !(ifAck || dAck) && !stall) stallBad++;
      if ((ifAck || dAck) && stall) stallBad++;
      if (dAck) begin
        dCnt++;
        if (dEdge == 0) dEdge = n + 1;
        dReq = 1'b0;
        ramRdata = rdB;
      end
      if (ifAck) begin
        ifCnt++;
        if (ifEdge == 0) ifEdge = n + 1;
        ifReq = 1'b0;
        ramRdata = rdB;
      end
    end
    check({tag, " d_ack edge"}, 32'(dEdge), 32'(expDEdge));
    check({tag, " if_ack edge"}, 32'(ifEdge), 32'(expIfEdge));
    check({tag, " d_ack count"}, 32'(dCnt), (expDEdge != 0) ? 32'd1 : 32'd0);
    check({tag, " if_ack count"}, 32'(ifCnt), (expIfEdge != 0) ? 32'd1 : 32'd0);
    check({tag, " write cycles"}, 32'(low), 32'(expLow));
    check({tag, " write bus"}, 32'(addrBad), 32'd0);
    check({tag, " stall"}, 32'(stallBad), 32'd0);
    check({tag, " if_rdata"}, 32'(ifRdata), 32'(expIfRd));
    check({tag, " d_rdata"}, 32'(dRdata), 32'(expDRd));
  endtask

  // Single access on the WAIT_CYCLES=1 instance.
  task automatic run1(input logic isData, input logic we, input logic [17:0] addr,
                      input logic [15:0] wd, input logic [15:0] rd,
                      input int expEdge, input int expLow,
                      input logic [15:0] expRd, input string tag);
    int edgeSeen = 0, cnt = 0, low = 0;
    @(negedge clk);
    ifReq1 = !isData; ifAddr1 = addr; dReq1 = isData; dWe1 = we;
    dAddr1 = addr; dWdata1 = wd; ramRdata1 = rd;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (!ramRead1) low++;
      if (ifAck1 || dAck1) begin
        cnt++;
        if (edgeSeen == 0) edgeSeen = n + 1;
        ifReq1 = 1'b0;
        dReq1  = 1'b0;
      end
    end
    check({tag, " ack edge"}, 32'(edgeSeen), 32'(expEdge));
    check({tag, " ack count"}, 32'(cnt), 32'd1);
    check({tag, " write cycles"}, 32'(low), 32'(expLow));
    check({tag, " rdata"}, 32'(isData ? dRdata1 : ifRdata1), 32'(expRd));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 18'h00010, 18'h00000, 16'h0000, 16'hBEEF, 16'h0000,
                4, 0, 0, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 18'h00000, 18'h3FFFF, 16'h1234, 16'hDEAD, 16'h0000,
                0, 4, 2, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 18'h00000, 18'h12345, 16'h0000, 16'hCAFE, 16'h0000,
                0, 4, 0, 16'hBEEF, 16'hCAFE};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 18'h00001, 18'h20000, 16'h0000, 16'h1111, 16'h2222,
                8, 4, 0, 16'h2222, 16'h1111};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 18'h3FFFF, 18'h00000, 16'hFFFF, 16'h5555, 16'h6666,
                8, 4, 2, 16'h6666, 16'h1111};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 18'h00000, 18'h00000, 16'h0000, 16'h0000, 16'h0000,
                4, 0, 0, 16'h0000, 16'h1111};

    // reset state
    repeat (3) @(negedge clk);
    check("reset ram_read", 32'(ramRead), 32'd1);
    check("reset ram_addr", 32'(ramAddr), 32'd0);
    check("reset ram_wdata", 32'(ramWdata), 32'd0);
    check("reset acks", 32'({ifAck, dAck}), 32'd0);
    check("reset rdata", 32'({ifRdata, dRdata}), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);
`ifdef MEM_PERF_CNT_EN
    check("perf after reset", 32'(perfStall), 32'd0);
`endif

    // table vectors
    for (int i = 0; i < 6; i++) begin
      runPair(vecs[i].doIf, vecs[i].doD, vecs[i].we, vecs[i].ifA, vecs[i].dA,
              vecs[i].wd, vecs[i].rdA, vecs[i].rdB, vecs[i].expIfEdge,
              vecs[i].expDEdge, vecs[i].expLow, vecs[i].expIfRd, vecs[i].expDRd,
              $sformatf("vec%0d", i));
      lastIf = vecs[i].expIfRd;
      lastD  = vecs[i].expDRd;
`ifdef MEM_PERF_CNT_EN
      if (i == 0) check("perf one access", 32'(perfStall), 32'd3);
`endif
    end

    // randomized transactions against the transaction-level model
    for (int i = 0; i < 40; i++) begin
      logic        rIf, rD, rWe;
      logic [17:0] rIfA, rDA;
      logic [15:0] rWd, rA, rB, eIf, eD;
      int          eIfEdge, eDEdge, eLow;
      rD   = 1'($urandom_range(0, 1));
      rIf  = rD ? 1'($urandom_range(0, 1)) : 1'b1;
      rWe  = 1'($urandom_range(0, 1));
      rIfA = 18'($urandom); rDA = 18'($urandom);
      rWd  = 16'($urandom); rA = 16'($urandom); rB = 16'($urandom);
      // data first; a losing fetch waits one full access plus its own
      eDEdge  = rD ? W + 2 : 0;
      eIfEdge = rIf ? (rD ? 2 * (W + 2) : W + 2) : 0;
      eLow    = (rD && rWe) ? W : 0;
      eD      = (rD && !rWe) ? rA : lastD;
      eIf     = rIf ? (rD ? rB : rA) : lastIf;
      runPair(rIf, rD, rWe, rIfA, rDA, rWd, rA, rB, eIfEdge, eDEdge, eLow,
              eIf, eD, $sformatf("rand%0d", i));
      lastIf = eIf;
      lastD  = eD;
    end

    // reset during the first ACCESS cycle of a write
    begin
      int acks = 0;
      @(negedge clk);
      dReq = 1'b1; dWe = 1'b1; dAddr = 18'h2AAAA; dWdata = 16'hA5A5;
      @(posedge clk);
      @(negedge clk);
      check("abort pre ram_read", 32'(ramRead), 32'd0);
      rst = 1'b1;
      dReq = 1'b0;
      #1;
      check("abort ram_read", 32'(ramRead), 32'd1);
      check("abort ram_addr", 32'(ramAddr), 32'd0);
      check("abort rdata", 32'({ifRdata, dRdata}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 6; n++) begin
        @(negedge clk);
        if (ifAck || dAck) acks++;
      end
      check("abort no ack", 32'(acks), 32'd0);
      lastIf = 16'd0;
      lastD  = 16'd0;
      runPair(1'b1, 1'b0, 1'b0, 18'h00123, 18'h0, 16'h0, 16'h7E57, 16'h0,
              4, 0, 0, 16'h7E57, 16'h0000, "post-abort");
    end

    // WAIT_CYCLES = 1 boundary
    run1(1'b0, 1'b0, 18'h00042, 16'h0000, 16'hA5A5, 3, 0, 16'hA5A5, "w1 fetch");
    run1(1'b1, 1'b1, 18'h3FFFF, 16'h9999, 16'hFFFF, 3, 1, 16'h0000, "w1 write");
    run1(1'b1, 1'b0, 18'h00007, 16'h0000, 16'h5A5A, 3, 0, 16'h5A5A, "w1 read");

`ifdef MEM_PERF_CNT_EN
    // stall counter saturates instead of wrapping
    begin
      int wrapped = 0;
      logic [15:0] prev;
      @(negedge clk);
      force dut.perfStallR = 16'hFFFC;
      @(negedge clk);
      release dut.perfStallR;
      prev = perfStall;
      ifReq = 1'b1; ifAddr = 18'h00001;
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        if (perfStall < prev) wrapped++;
        prev = perfStall;
      end
      ifReq = 1'b0;
      repeat (6) @(negedge clk);
      check("perf no wrap", 32'(wrapped), 32'd0);
      check("perf saturated", 32'(perfStall), 32'h0000FFFF);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
